scansione_video: RTL and testbench

Raster scan generator driving the pixel coordinates consumed by the shape hit-test blocks (rectangle, frame) and the sync signals sent to the monitor. Two cascaded counters walk every pixel of a 1280×1024@60 Hz frame (porches and sync included); it publishes the current pixel as X_CONTROLLO/Y_CONTROLLO plus HSYNC, VSYNC, ACTIVE and start-of-line/frame strobes. It is the producing end of the coordinate interface: every shape block in the display path is fed from this unit.

---
 rtl/scansione_video.sv | 121 ++++++++++++
 tb/tb_scansione_video.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scansione_video.sv
// Raster scan generator: cascaded pixel/line counters with registered sync, active and strobe flags.
// Define SCANSIONE_PIPE_EN to delay HSYNC/VSYNC/ACTIVE by one enabled pixel step.
module scansione_video #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    output logic [10:0] X_CONTROLLO,
    output logic [10:0] Y_CONTROLLO,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        ACTIVE,
    output logic        LINE_START,
    output logic        FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] Y_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
        $error("scansione_video: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    function automatic logic sync_lvl(input logic on);
        return SYNC_POL ? on : ~on;
    endfunction

    logic [10:0] x_q, x_d, y_q, y_d;
    logic        hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic        ls_q, ls_d, fs_q, fs_d;

    // Flags are derived from the next counter values so they register together with X/Y.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (EN) begin
            if (x_q == X_LAST) begin
                x_d  = '0;
                y_d  = (y_q == Y_LAST) ? 11'd0 : y_q + 11'd1;
                ls_d = 1'b1;
                fs_d = (y_q == Y_LAST);
            end else begin
                x_d = x_q + 11'd1;
            end
        end
        hs_d  = sync_lvl((x_d >= HS_BEG) && (x_d < HS_END));
        vs_d  = sync_lvl((y_d >= VS_BEG) && (y_d < VS_END));
        act_d = (x_d < X_VIS) && (y_d < Y_VIS);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x_q   <= X_LAST;
            y_q   <= Y_LAST;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            act_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

`ifdef SCANSIONE_PIPE_EN
    logic hs_p_q, vs_p_q, act_p_q;

    // Extra stage lines the levels up with consumers that register their hit-test result.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hs_p_q  <= ~SYNC_POL;
            vs_p_q  <= ~SYNC_POL;
            act_p_q <= 1'b0;
        end else if (EN) begin
            hs_p_q  <= hs_q;
            vs_p_q  <= vs_q;
            act_p_q <= act_q;
        end
    end

    assign HSYNC  = hs_p_q;
    assign VSYNC  = vs_p_q;
    assign ACTIVE = act_p_q;
`else
    assign HSYNC  = hs_q;
    assign VSYNC  = vs_q;
    assign ACTIVE = act_q;
`endif

    assign X_CONTROLLO = x_q;
    assign Y_CONTROLLO = y_q;
    assign LINE_START  = ls_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_scansione_video.sv
// Scoreboard bench for scansione_video: a full-size instance and a small-frame instance share stimulus.
module tb_scansione_video;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic EN = 1'b0;

    always #5 CLK = ~CLK;

    logic [10:0] b_x, b_y, s_x, s_y;
    logic        b_hs, b_vs, b_act, b_ls, b_fs;
    logic        s_hs, s_vs, s_act, s_ls, s_fs;

    scansione_video u_big (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .X_CONTROLLO(b_x), .Y_CONTROLLO(b_y),
        .HSYNC(b_hs), .VSYNC(b_vs), .ACTIVE(b_act),
        .LINE_START(b_ls), .FRAME_START(b_fs)
    );

    // 16 x 8 frame, active-low syncs: hsync x=10..12, vsync y=5..6, visible 8 x 4.
    scansione_video #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0)
    ) u_small (
        .CLK(CLK), .RESET(RESET), .EN(EN),
        .X_CONTROLLO(s_x), .Y_CONTROLLO(s_y),
        .HSYNC(s_hs), .VSYNC(s_vs), .ACTIVE(s_act),
        .LINE_START(s_ls), .FRAME_START(s_fs)
    );

    typedef struct {
        int          id;
        logic [10:0] bx, by, sx, sy;
        logic        bhs, bvs, bact, bls, bfs;
        logic        shs, svs, sact, sls, sfs;
    } exp_t;

    exp_t q[$];
    event async_ev;
    int   n_chk = 0;
    int   n_fail = 0;
    int   step_id = 0;
    int   sfs_exp = 0;
    int   sfs_seen = 0;

    // Reference model state
    logic [10:0] mbx, mby, msx, msy;
    logic        mbls, mbfs, msls, msfs;
    logic        pb_hs, pb_vs, pb_act, ps_hs, ps_vs, ps_act;

    function automatic logic big_hs(input logic [10:0] x);
        return (x >= 11'd1328) && (x < 11'd1440);
    endfunction
    function automatic logic big_vs(input logic [10:0] y);
        return (y >= 11'd1025) && (y < 11'd1028);
    endfunction
    function automatic logic big_act(input logic [10:0] x, input logic [10:0] y);
        return (x < 11'd1280) && (y < 11'd1024);
    endfunction
    function automatic logic sm_hs(input logic [10:0] x);
        return (x >= 11'd10) && (x < 11'd13);
    endfunction
    function automatic logic sm_vs(input logic [10:0] y);
        return (y >= 11'd5) && (y < 11'd7);
    endfunction
    function automatic logic sm_act(input logic [10:0] x, input logic [10:0] y);
        return (x < 11'd8) && (y < 11'd4);
    endfunction

    task automatic model_reset();
        mbx = 11'd1687; mby = 11'd1065; msx = 11'd15; msy = 11'd7;
        mbls = 1'b0; mbfs = 1'b0; msls = 1'b0; msfs = 1'b0;
        pb_hs = 1'b0; pb_vs = 1'b0; pb_act = 1'b0;
        ps_hs = 1'b0; ps_vs = 1'b0; ps_act = 1'b0;
    endtask

    task automatic model_adv(input logic en);
        mbls = 1'b0; mbfs = 1'b0; msls = 1'b0; msfs = 1'b0;
        if (en) begin
            pb_hs = big_hs(mbx); pb_vs = big_vs(mby); pb_act = big_act(mbx, mby);
            ps_hs = sm_hs(msx);  ps_vs = sm_vs(msy);  ps_act = sm_act(msx, msy);
            if (mbx == 11'd1687) begin
                mbx = 11'd0;
                mby = (mby == 11'd1065) ? 11'd0 : mby + 11'd1;
            end else mbx = mbx + 11'd1;
            if (msx == 11'd15) begin
                msx = 11'd0;
                msy = (msy == 11'd7) ? 11'd0 : msy + 11'd1;
            end else msx = msx + 11'd1;
            mbls = (mbx == 11'd0); mbfs = mbls && (mby == 11'd0);
            msls = (msx == 11'd0); msfs = msls && (msy == 11'd0);
            if (msfs) sfs_exp++;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        step_id++;
        e.id = step_id;
        e.bx = mbx; e.by = mby; e.sx = msx; e.sy = msy;
        e.bls = mbls; e.bfs = mbfs; e.sls = msls; e.sfs = msfs;
`ifdef SCANSIONE_PIPE_EN
        e.bhs = pb_hs;  e.bvs = pb_vs;  e.bact = pb_act;
        e.shs = ~ps_hs; e.svs = ~ps_vs; e.sact = ps_act;
`else
        e.bhs = big_hs(mbx);  e.bvs = big_vs(mby);  e.bact = big_act(mbx, mby);
        e.shs = ~sm_hs(msx);  e.svs = ~sm_vs(msy);  e.sact = sm_act(msx, msy);
`endif
        q.push_back(e);
    endtask

    task automatic step(input logic en, input logic rst_v);
        @(negedge CLK);
        EN = en;
        RESET = rst_v;
        if (rst_v) model_reset();
        else model_adv(en);
        push_exp();
        @(posedge CLK);
    endtask

    task automatic async_reset();
        @(negedge CLK);
        #2;
        model_reset();
        push_exp();
        RESET = 1'b1;
        -> async_ev;
    endtask

    task automatic chk11(input string nm, input int id, input logic [10:0] a, input logic [10:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, id, a, e);
        end
    endtask

    task automatic chk1(input string nm, input int id, input logic a, input logic e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b expected %b", nm, id, a, e);
        end
    endtask

    // Monitor: one expected entry per clock edge or asynchronous reset event.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or async_ev);
            #1;
            if (s_fs === 1'b1) sfs_seen++;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk11("big_x", e.id, b_x, e.bx);
                chk11("big_y", e.id, b_y, e.by);
                chk1("big_hsync", e.id, b_hs, e.bhs);
                chk1("big_vsync", e.id, b_vs, e.bvs);
                chk1("big_active", e.id, b_act, e.bact);
                chk1("big_line_start", e.id, b_ls, e.bls);
                chk1("big_frame_start", e.id, b_fs, e.bfs);
                chk11("small_x", e.id, s_x, e.sx);
                chk11("small_y", e.id, s_y, e.sy);
                chk1("small_hsync", e.id, s_hs, e.shs);
                chk1("small_vsync", e.id, s_vs, e.svs);
                chk1("small_active", e.id, s_act, e.sact);
                chk1("small_line_start", e.id, s_ls, e.sls);
                chk1("small_frame_start", e.id, s_fs, e.sfs);
            end
        end
    end

    initial begin
        model_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (1688) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (640) step(1'b1, 1'b0);
        async_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (300) step(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) step((i % 3) != 0, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #3;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        n_chk++;
        if (sfs_seen != sfs_exp) begin
            n_fail++;
            $display("FAIL small_frame_count: got %0d expected %0d", sfs_seen, sfs_exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
